vector_sum_arbiter: RTL and testbench
=====================================

# vector_sum_arbiter

Round-robin scheduler that shares one `vectorSum` adder-tree instance among NREQ requesters in the matrix-multiply engine. Each requester presents a DIM-element vector with a valid/ready handshake. The arbiter grants at most one vector per cycle, drives it into `vectorSum`, and tracks the granted requester ID through the adder latency. It returns each sum tagged with its originating requester.

## Interface
- `DIM`, 2, elements per vector
- `W_u`, 8, bits per element
- `NREQ`, 4, number of requesters (≥2)
- `LAT`, 1, `vectorSum` latency in cycles from `u` to `sum` (≥1)
- `Clock`  in  1  single clock, rising-edge
- `Reset`  in  1  synchronous, active-high
- `req_valid`  in  NREQ  per-requester vector valid
- `req_ready`  out  NREQ  per-requester grant; one-hot or zero
- `req_vec`  in  NREQ*DIM*W_u  requester i occupies bits [(i+1)*DIM*W_u-1 : i*DIM*W_u]
- `vs_u`  out  DIM*W_u  to `vectorSum` `u`
- `vs_sum`  in  W_u+clog2(DIM)  from `vectorSum` `sum`
- `resp_valid`  out  1  single-cycle result strobe
- `resp_id`  out  clog2(NREQ)  requester that owns `resp_sum`
- `resp_sum`  out  W_u+clog2(DIM)  sum result
- `grant_count`  out  NREQ*16  present only with `VSUM_ARB_STATS_EN`

## Operation
- Handshake: transfer on `req_valid[i] & req_ready[i]`. `req_ready` is combinational from `req_valid` and the priority pointer. A requester must hold `req_vec` slice and `req_valid` until ready.
- Arbitration: round-robin. Search starts at `last+1` mod NREQ and grants the first valid requester. `last` updates to the granted index on a transfer and holds when there is no transfer.
- Datapath: `vs_u` = granted requester's slice; 0 when nothing is granted.
- Tag pipeline: LAT-stage shift register of {valid, id}. Stage 0 loads {transfer, granted index} each cycle.
- Output: `resp_valid` = stage LAT-1 valid, `resp_id` = its id, `resp_sum` = `vs_sum` (pass-through, no extra register).
- No response backpressure. Results are never stalled or dropped except on reset.
- Width: `resp_sum` is W_u+clog2(DIM) bits, unsigned, no overflow possible.

## Timing
- Reset values:
  - `req_ready` = 0 during `Reset`, `vs_u` = 0, `resp_valid` = 0, `resp_id` = 0, `resp_sum` follows `vs_sum`.
  - `last` = NREQ-1, so requester 0 has first priority.
  - All tag stages invalid, `grant_count` = 0.
- Latency: vector accepted at edge N yields `resp_valid` high for exactly one cycle, sampled at edge N+LAT.
- Throughput: one vector per cycle; back-to-back grants allowed to the same requester only if no other requester is valid.
- Simultaneous requests: exactly one granted per cycle; others wait. With all NREQ valid continuously, each is served once every NREQ cycles.
- Reset mid-operation: in-flight tags are cleared on the reset edge. No `resp_valid` is produced for vectors accepted before reset.
- Reset and `req_valid` in the same cycle: no grant, no transfer.

## Configuration
- `VSUM_ARB_STATS_EN` defined:
  - Adds `grant_count` port: one 16-bit counter per requester, incrementing on each transfer.
  - Counters wrap at 0xFFFF→0 and are cleared by `Reset`.
- Not defined: no port, no counters; arbitration and timing are identical.

## Structure
- Shared package `vsum_pkg`:
  - `clog2` constant function.
  - ID width and sum width localparams derived from NREQ/DIM/W_u.
  - Tag struct {valid, id}.
- Sub-module `rr_arbiter` (NREQ, req in, one-hot grant out, index out, advance input, pointer state). The top holds the vector mux, tag pipeline and stats counters.

## Test plan
All scenarios use DIM=2, W_u=8, NREQ=4, LAT=1, with a behavioural `vectorSum` model.
- Only requester 2 valid with `vec`=16'h0801 → `req_ready`=4'b0100 that cycle; next cycle `resp_valid`=1, `resp_id`=2, `resp_sum`=9.
- All four valid continuously after reset → grant order 0,1,2,3,0,1; `resp_id` sequence is identical, delayed by 1 cycle.
- Requesters 1 and 3 valid, last grant was 1 → grant 3; then 1; then 3.
- Requester 0 `vec`=16'hFFFF → `resp_sum`=510 (9'h1FE), no truncation.
- Accept at edge N, `Reset` high for edge N+1 → `resp_valid` stays 0; after release, requester 0 is granted first.
- With `VSUM_ARB_STATS_EN`, 10 grants to requester 1 → `grant_count[31:16]`=10, others 0; after reset all 0.

Source files
------------

// File: rtl/vsum_pkg.sv
// Shared types and width helpers for the vectorSum arbiter slice.
// Defaults here match the standard matrix-multiply engine configuration.
package vsum_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int DIM_DEF  = 2;
  localparam int W_U_DEF  = 8;
  localparam int NREQ_DEF = 4;
  localparam int LAT_DEF  = 1;

  localparam int ID_W  = clog2(NREQ_DEF);
  localparam int SUM_W = W_U_DEF + clog2(DIM_DEF);

  // Tag id is held wide so any practical NREQ fits without changing the type.
  localparam int TAG_ID_W = 16;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/vector_sum_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index.
// The pointer only moves when the caller signals an accepted transfer.
module rr_arbiter
  import vsum_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = clog2(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx
);

  logic [IDW-1:0] r_last;
  logic [IDW-1:0] w_cand;
  logic           w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(r_last) + k) % NREQ);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)          r_last <= IDW'(NREQ - 1);
    else if (i_advance) r_last <= o_idx;
  end

endmodule

// File: rtl/vector_sum_arbiter.sv
// Shares one vectorSum adder tree among NREQ requesters and tags each sum.
// Optional per-requester grant counters are enabled by VSUM_ARB_STATS_EN.
module vector_sum_arbiter
  import vsum_pkg::*;
#(
  parameter  int DIM  = DIM_DEF,
  parameter  int W_u  = W_U_DEF,
  parameter  int NREQ = NREQ_DEF,
  parameter  int LAT  = LAT_DEF,
  localparam int IDW  = clog2(NREQ),
  localparam int SW   = W_u + clog2(DIM),
  localparam int VW   = DIM * W_u
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*VW-1:0] req_vec,
  output logic [VW-1:0]      vs_u,
  input  logic [SW-1:0]      vs_sum,
  output logic               resp_valid,
  output logic [IDW-1:0]     resp_id,
  output logic [SW-1:0]      resp_sum
`ifdef VSUM_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] grant_count
`endif
);

  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic            w_xfer;
  tag_t            r_tag_p [LAT];

  // Requests are masked during reset so nothing transfers on a reset edge.
  assign w_req     = Reset ? '0 : req_valid;
  assign w_xfer    = |w_grant;
  assign req_ready = w_grant;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_clk    (Clock),
    .i_rst    (Reset),
    .i_req    (w_req),
    .i_advance(w_xfer),
    .o_grant  (w_grant),
    .o_idx    (w_idx)
  );

  always_comb begin
    vs_u = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_grant[i]) vs_u = req_vec[i*VW +: VW];
  end

  // Stage boundary: tag shift register tracks the adder latency.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int s = 0; s < LAT; s++) r_tag_p[s] <= '0;
    end else begin
      r_tag_p[0] <= '{valid: w_xfer, id: TAG_ID_W'(w_idx)};
      for (int s = 1; s < LAT; s++) r_tag_p[s] <= r_tag_p[s-1];
    end
  end

  // Gated by Reset so a tag accepted just before reset never strobes out.
  assign resp_valid = r_tag_p[LAT-1].valid & ~Reset;
  assign resp_id    = Reset ? '0 : IDW'(r_tag_p[LAT-1].id);
  assign resp_sum   = vs_sum;

`ifdef VSUM_ARB_STATS_EN
  logic [NREQ*16-1:0] r_grant_count;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_grant_count <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (w_grant[i]) r_grant_count[i*16 +: 16] <= r_grant_count[i*16 +: 16] + 16'd1;
    end
  end

  assign grant_count = r_grant_count;
`endif

endmodule

// File: tb/tb_vector_sum_arbiter.sv
// Directed bench for vector_sum_arbiter (DIM=2, W_u=8, NREQ=4, LAT=1)
// with a behavioural one-cycle vectorSum model.
module tb_vector_sum_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_vec;
  logic [15:0] vs_u;
  logic [8:0]  vs_sum;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [8:0]  resp_sum;
`ifdef VSUM_ARB_STATS_EN
  logic [63:0] grant_count;
`endif

  int total = 0;
  int bad   = 0;

  vector_sum_arbiter #(.DIM(2), .W_u(8), .NREQ(4), .LAT(1)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vec   (req_vec),
    .vs_u      (vs_u),
    .vs_sum    (vs_sum),
    .resp_valid(resp_valid),
    .resp_id   (resp_id),
    .resp_sum  (resp_sum)
`ifdef VSUM_ARB_STATS_EN
    ,
    .grant_count(grant_count)
`endif
  );

  always #5 Clock = ~Clock;

  // Behavioural vectorSum: one register stage after the element add.
  always @(posedge Clock) vs_sum <= {1'b0, vs_u[15:8]} + {1'b0, vs_u[7:0]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_vecs();
    req_vec[15:0]  = 16'h0201;
    req_vec[31:16] = 16'h1010;
    req_vec[47:32] = 16'h0801;
    req_vec[63:48] = 16'h7F80;
  endtask

  logic [1:0] exp_order [6];
  logic [8:0] exp_sum   [4];

  initial begin
    exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd2;
    exp_order[3] = 2'd3; exp_order[4] = 2'd0; exp_order[5] = 2'd1;
    exp_sum[0] = 9'd3; exp_sum[1] = 9'd32; exp_sum[2] = 9'd9; exp_sum[3] = 9'd255;

    // Reset asserted together with all requests valid: no grant.
    Reset     = 1'b1;
    req_valid = 4'hF;
    set_vecs();
    tick();
    @(negedge Clock);
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_vs_u", 64'(vs_u), 64'h0);
    tick();
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_resp_id", 64'(resp_id), 64'h0);
`ifdef VSUM_ARB_STATS_EN
    chk("rst_grant_count", grant_count, 64'h0);
`endif

    // Only requester 2 valid.
    Reset     = 1'b0;
    req_valid = 4'b0100;
    @(negedge Clock);
    chk("r2_ready", 64'(req_ready), 64'h4);
    chk("r2_vs_u", 64'(vs_u), 64'h0801);
    tick();
    req_valid = 4'b0000;
    chk("r2_resp_valid", 64'(resp_valid), 64'h1);
    chk("r2_resp_id", 64'(resp_id), 64'h2);
    chk("r2_resp_sum", 64'(resp_sum), 64'd9);
    tick();
    chk("idle_resp_valid", 64'(resp_valid), 64'h0);
    @(negedge Clock);
    chk("idle_vs_u", 64'(vs_u), 64'h0);

    // Fresh reset, then all four valid continuously.
    Reset = 1'b1;
    tick();
    Reset     = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      chk($sformatf("all_ready_%0d", k), 64'(req_ready), 64'(4'b0001 << exp_order[k]));
      tick();
      chk($sformatf("all_valid_%0d", k), 64'(resp_valid), 64'h1);
      chk($sformatf("all_id_%0d", k), 64'(resp_id), 64'(exp_order[k]));
      chk($sformatf("all_sum_%0d", k), 64'(resp_sum), 64'(exp_sum[exp_order[k]]));
    end

    // Requesters 1 and 3 valid after last grant went to 1: 3, 1, 3.
    req_valid = 4'b1010;
    @(negedge Clock);
    chk("p13_ready_a", 64'(req_ready), 64'h8);
    tick();
    chk("p13_id_a", 64'(resp_id), 64'h3);
    @(negedge Clock);
    chk("p13_ready_b", 64'(req_ready), 64'h2);
    tick();
    chk("p13_id_b", 64'(resp_id), 64'h1);
    @(negedge Clock);
    chk("p13_ready_c", 64'(req_ready), 64'h8);
    tick();
    chk("p13_id_c", 64'(resp_id), 64'h3);

    // Maximum element values: no truncation of the sum.
    req_valid      = 4'b0001;
    req_vec[15:0]  = 16'hFFFF;
    @(negedge Clock);
    chk("max_ready", 64'(req_ready), 64'h1);
    tick();
    chk("max_valid", 64'(resp_valid), 64'h1);
    chk("max_id", 64'(resp_id), 64'h0);
    chk("max_sum", 64'(resp_sum), 64'h1FE);

    // Accept at edge N, reset across edge N+1: no response, pointer restarts.
    req_valid = 4'b0010;
    @(negedge Clock);
    chk("mid_ready", 64'(req_ready), 64'h2);
    tick();
    Reset     = 1'b1;
    req_valid = 4'b0000;
    @(negedge Clock);
    chk("mid_resp_valid_a", 64'(resp_valid), 64'h0);
    tick();
    chk("mid_resp_valid_b", 64'(resp_valid), 64'h0);
    Reset     = 1'b0;
    req_valid = 4'hF;
    @(negedge Clock);
    chk("post_rst_ready", 64'(req_ready), 64'h1);
    tick();
    chk("post_rst_id", 64'(resp_id), 64'h0);
    req_valid = 4'b0000;

`ifdef VSUM_ARB_STATS_EN
    Reset = 1'b1;
    tick();
    Reset     = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 10; k++) tick();
    req_valid = 4'b0000;
    tick();
    chk("stats_count", grant_count, {16'd0, 16'd0, 16'd10, 16'd0});
    Reset = 1'b1;
    tick();
    chk("stats_cleared", grant_count, 64'h0);
    Reset = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
